sb_rr_arbiter: RTL and testbench
================================

# sb_rr_arbiter

Parametrised N-master system-bus arbiter with registered one-hot grants, round-robin fairness, bus-lock hold and split-transaction masking. It sits between the bus masters and the address/control multiplexer. It drives the grant lines and owner ID that steer the master mux, and takes split responses and split releases back from the slaves. It replaces the fixed two-master arbiter for any bus with 2 to 16 masters.

## Interface
- NUM_MASTERS, 4, number of masters (2..16)
- ID_WIDTH, 2, width of master_id; must satisfy 2^ID_WIDTH >= NUM_MASTERS
- clk  in  1  bus clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_MASTERS  bus request, bit i = master i
- lock  in  NUM_MASTERS  lock request, bit i = master i; only the owner's bit is used
- xfer_done  in  1  the owner's current transfer completes this cycle
- split_set  in  1  the slave returned SPLIT to the current owner this cycle
- split_release  in  NUM_MASTERS  the slave unmasks master i (pulse)
- gnt  out  NUM_MASTERS  registered one-hot grant, all-zero when the bus is unowned
- master_id  out  ID_WIDTH  registered index of the owner; holds the last owner when the bus is unowned
- mastlock  out  1  registered: the owner holds the bus locked
- bus_busy  out  1  registered: gnt is non-zero
- split_mask  out  NUM_MASTERS  registered set of masters excluded by split

## Operation
- Eligible set is req & ~split_mask, using split_mask after this cycle's release is applied.
- Winner: the first eligible index searching upward from (last_id+1) mod NUM_MASTERS, with wrap-around. last_id is the index of the most recent grant.
- States:
  - IDLE: gnt = 0.
  - BUSY: exactly one gnt bit is set.
- IDLE transitions:
  - Eligible set non-empty: go to BUSY. gnt, master_id and last_id take the winner. mastlock = lock[winner].
  - Eligible set empty: stay in IDLE.
- BUSY release events:
  - (xfer_done or ~req[owner]) while lock[owner] = 0.
  - split_set.
- BUSY priority order:
  - split_set first, and it overrides lock: set split_mask[owner] and go to IDLE with gnt = 0. Re-arbitration happens in the next cycle.
  - Otherwise, lock[owner] = 1: hold the grant and ignore xfer_done and req.
  - Otherwise, a release event: the winner is taken directly in the same edge with no idle cycle. The winner may be the same master if it is the only eligible requester. If the eligible set is empty, go to IDLE.
  - Otherwise: hold the grant.
- mastlock follows lock[owner] each cycle while BUSY, registered. It is 0 in IDLE.
- split_mask update each cycle is (split_mask & ~split_release) | (split_set ? onehot(owner) : 0). A set on the same bit as a release wins.
- split_set is ignored in IDLE.
- Req bits at or above NUM_MASTERS do not exist. Out-of-range IDs are never produced.

## Timing
- Reset values: state IDLE, gnt = 0, master_id = 0, mastlock = 0, bus_busy = 0, split_mask = 0, last_id = NUM_MASTERS-1, so master 0 has first priority.
- Reset asserted mid-transfer clears everything immediately (asynchronous). The first grant can appear at the first rising edge after rst deasserts.
- Request to grant latency is 1 clock from IDLE: req sampled at edge k gives gnt valid after edge k.
- Handover on xfer_done is 1 clock with no bubble.
- Split to next grant is 2 clocks: one IDLE bubble.
- All outputs are glitch-free flops. No combinational path from any input to any output.

## Test plan
- NUM_MASTERS=4, rst pulse, req=4'b1010 held -> gnt=0010, id=1 after first edge; xfer_done pulse -> gnt=1000, id=3; next xfer_done -> gnt=0010 (wrap-around).
- Owner 1 with lock[1]=1, req=4'b1010, xfer_done pulsed 3 times -> gnt stays 0010 and mastlock=1. Then lock[1]=0 plus xfer_done -> gnt=1000 and mastlock=0.
- Owner 2 locked, req=4'b0101, split_set -> next cycle gnt=0000, split_mask=0100. The following cycle gnt=0001. Master 2 is never granted until split_release[2]=1, after which it wins in round-robin order.
- split_set and split_release[owner] in the same cycle -> split_mask bit is set. With all requesters masked (req=0100, mask=0100) the block stays IDLE and bus_busy=0.
- Owner 0 drops req with lock=0 and no xfer_done, other requests 0 -> IDLE next cycle, gnt=0, master_id stays 0.
- rst asserted while BUSY with split_mask=1010 -> all outputs go to their reset values without a clock edge. After deassert with req=4'b1111, the first grant is gnt=0001.

Source files
------------

// File: rtl/sb_rr_arbiter.sv
// N-master system-bus arbiter: registered one-hot grant, round-robin fairness,
// bus-lock hold and split-transaction masking of masters until the slave releases them.
module sb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] lock,
  input  logic                   xfer_done,
  input  logic                   split_set,
  input  logic [NUM_MASTERS-1:0] split_release,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [ID_WIDTH-1:0]    master_id,
  output logic                   mastlock,
  output logic                   bus_busy,
  output logic [NUM_MASTERS-1:0] split_mask
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic                   lock_q, lock_d;
  logic                   busy_q, busy_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic [ID_WIDTH-1:0]    last_q, last_d;

  logic [NUM_MASTERS-1:0] mask_rel;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic                   hi_found, lo_found, win_found;
  logic [ID_WIDTH-1:0]    hi_id, lo_id, win_id;
  logic                   own_lock, own_req, win_lock;

  // Releases take effect in the same cycle, so a released master can win right away.
  assign mask_rel = mask_q & ~split_release;
  assign eligible = req & ~mask_rel;

  // Round-robin: lowest eligible index above last_q, else lowest eligible overall.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_WIDTH'(i);
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_id    = ID_WIDTH'(i);
        end
      end
    end
    win_found = lo_found;
    win_id    = hi_found ? hi_id : lo_id;
  end

  assign win_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_id;
  assign win_lock   = |(win_onehot & lock);
  assign own_lock   = |(gnt_q & lock);
  assign own_req    = |(gnt_q & req);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    lock_d  = lock_q;
    last_d  = last_q;
    mask_d  = mask_rel;
    unique case (state_q)
      IDLE: begin
        lock_d = 1'b0;
        if (win_found) begin
          state_d = BUSY;
          gnt_d   = win_onehot;
          id_d    = win_id;
          last_d  = win_id;
          lock_d  = win_lock;
        end
      end
      BUSY: begin
        if (split_set) begin
          // Split overrides lock; the set bit wins over a same-cycle release.
          mask_d  = mask_rel | gnt_q;
          state_d = IDLE;
          gnt_d   = '0;
          lock_d  = 1'b0;
        end else if (own_lock) begin
          lock_d = 1'b1;
        end else if (xfer_done || !own_req) begin
          if (win_found) begin
            gnt_d  = win_onehot;
            id_d   = win_id;
            last_d = win_id;
            lock_d = win_lock;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            lock_d  = 1'b0;
          end
        end else begin
          lock_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        lock_d  = 1'b0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      lock_q  <= 1'b0;
      busy_q  <= 1'b0;
      mask_q  <= '0;
      last_q  <= ID_WIDTH'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  assign gnt        = gnt_q;
  assign master_id  = id_q;
  assign mastlock   = lock_q;
  assign bus_busy   = busy_q;
  assign split_mask = mask_q;

endmodule

// File: tb/tb_sb_rr_arbiter.sv
// Directed-vector bench for sb_rr_arbiter (4 masters): table of per-cycle inputs
// with hand-computed registered outputs, plus an asynchronous-reset sequence.
module tb_sb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, lock, split_release;
  logic       xfer_done, split_set;
  logic [3:0] gnt, split_mask;
  logic [1:0] master_id;
  logic       mastlock, bus_busy;

  int total = 0;
  int bad   = 0;

  sb_rr_arbiter #(.NUM_MASTERS(4), .ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .xfer_done(xfer_done),
    .split_set(split_set), .split_release(split_release), .gnt(gnt),
    .master_id(master_id), .mastlock(mastlock), .bus_busy(bus_busy),
    .split_mask(split_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic       xd;
    logic       ss;
    logic [3:0] sr;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       ml;
    logic       busy;
    logic [3:0] mask;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  task automatic check(input string name, input logic [3:0] e_gnt, input logic [1:0] e_id,
                       input logic e_ml, input logic e_busy, input logic [3:0] e_mask);
    total++;
    if ({gnt, master_id, mastlock, bus_busy, split_mask} !== {e_gnt, e_id, e_ml, e_busy, e_mask}) begin
      bad++;
      $display("FAIL %s: got gnt=%b id=%0d ml=%b busy=%b mask=%b, want gnt=%b id=%0d ml=%b busy=%b mask=%b",
               name, gnt, master_id, mastlock, bus_busy, split_mask,
               e_gnt, e_id, e_ml, e_busy, e_mask);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             req      lock     xd    ss    sr       gnt      id     ml    busy  mask
    tv[0]  = '{4'b1010, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000};
    tv[1]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 4'b0000};
    tv[2]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000};
    tv[3]  = '{4'b1010, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000};
    tv[4]  = '{4'b1010, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000};
    tv[5]  = '{4'b1010, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000};
    tv[6]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 4'b0000};
    tv[7]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000};
    tv[8]  = '{4'b0101, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100};
    tv[9]  = '{4'b0101, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0100};
    tv[10] = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0100};
    tv[11] = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1, 4'b0000};
    tv[12] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100};
    tv[13] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100};
    tv[14] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100};
    tv[15] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0000};
    tv[16] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tv[17] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tv[18] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000};
    tv[19] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0010};
    tv[20] = '{4'b1000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b1, 4'b0010};
    tv[21] = '{4'b1000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 4'b1010};
    tv[22] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1, 4'b1010};

    rst = 1'b1;
    req = '0; lock = '0; xfer_done = 1'b0; split_set = 1'b0; split_release = '0;
    #2;
    check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    #5 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req = tv[i].req; lock = tv[i].lock; xfer_done = tv[i].xd;
      split_set = tv[i].ss; split_release = tv[i].sr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tv[i].gnt, tv[i].id, tv[i].ml, tv[i].busy, tv[i].mask);
    end

    // Asynchronous reset while busy with split_mask=1010: clears with no clock edge.
    req = 4'b1111; lock = '0; xfer_done = 1'b0; split_set = 1'b0; split_release = '0;
    #2 rst = 1'b1;
    #1;
    check("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", 4'b0001, 2'd0, 1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    xfer_done = 1'b1;
    @(posedge clk);
    #1;
    check("handover_after_reset", 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    xfer_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
